hp48_bus_master: RTL and testbench
==================================

Name: hp48_bus_master

Overview:
CPU-side initiator for the HP48 nibble bus. It accepts one burst request (PC read, DP read or DP write of 1..16 nibbles) and sequences it onto the flat bus as one nibble per clock. It drives address, command and write nibble, and collects read nibbles into a 64-bit buffer. It sits between the Saturn core's fetch/memory-access logic and the bus manager, and aborts cleanly on bus_error.

Parameters:
READ_LATENCY, 1, cycles from a read bus cycle to valid bus_nibble_in (legal 0..3; 0 = same cycle)

Ports:
clk  in  1  clock; all state on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
req_valid  in  1  request strobe
req_ready  out  1  high only in IDLE; request accepted when req_valid && req_ready
req_op  in  2  00 PC_READ, 01 DP_READ, 10 DP_WRITE, 11 reserved
req_addr  in  20  start nibble address
req_len  in  4  nibble count minus 1 (0..15 = 1..16 nibbles)
req_wdata  in  64  write data; nibble i = bits [4i+3:4i]
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  64  read data, same nibble packing; held until next accept
rsp_error  out  1  valid with rsp_valid; held with rsp_rdata
bus_address  out  20  bus address
bus_command  out  4  BUSCMD_* code
bus_nibble_out  out  4  write nibble toward bus
bus_nibble_in  in  4  read nibble from bus manager
bus_error  in  1  bus error from bus manager

Behaviour:
- Clock is clk. Reset is asynchronous and active-high, named reset.
- Reset values: state IDLE; bus_address=0; bus_command=BUSCMD_NOP; bus_nibble_out=0; rsp_valid=0; rsp_rdata=0; rsp_error=0. req_ready=1 (decoded from IDLE). Pipeline and counters cleared.
- Reset mid-burst aborts with no response pulse.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - bus_command=NOP.
  - On accept, latch op, addr, len, wdata; clear rsp_rdata and rsp_error; set index i=0.
  - Go to ISSUE, or DONE with rsp_error=1 if op=11. No bus cycle is issued for op=11.
- ISSUE, one bus cycle per clock:
  - bus_address=(addr+i) mod 2^20, so the address wraps FFFFF->00000.
  - bus_command=PC_READ, DP_READ or DP_WRITE.
  - bus_nibble_out=wdata nibble i for DP_WRITE, else 0.
  - When i==len, next state is DRAIN for reads with READ_LATENCY>0, otherwise DONE.
- Read capture: the nibble for index k is sampled READ_LATENCY cycles after the bus cycle for k and written into rsp_rdata[4k+3:4k]. Unreached nibbles stay 0.
- DRAIN: bus_command=NOP for exactly READ_LATENCY cycles while the capture pipeline empties, then DONE.
- DONE: rsp_valid=1 for one cycle, then IDLE. The bus is idle (NOP, nibble 0).
- Latency, with accept in cycle 0: bus cycles run 1..len+1. rsp_valid occurs at cycle len+2 for writes and at len+2+READ_LATENCY for reads.
- bus_error is sampled in ISSUE and DRAIN.
  - On assertion: next cycle bus_command=NOP, the capture pipeline is flushed, and the state goes to DONE with rsp_error=1.
  - Nibbles captured before the error are kept.
  - Simultaneous error and last issue: the error wins.
- req_valid outside IDLE is ignored (req_ready=0).
- A back-to-back request can be accepted in the cycle after rsp_valid.

Decomposition:
- Shared include:
  - BUSCMD_* codes (NOP, PC_READ, DP_READ, DP_WRITE), from the existing bus command definitions.
  - req_op encodings.
  - State encoding.
- Sub-module hp48_bus_rd_pipe:
  - READ_LATENCY-deep delay line of {valid, index[3:0]}.
  - Has a flush input.
  - Outputs the capture strobe and capture index.

Test Plan:
- PC_READ addr=0x00100 len=4, READ_LATENCY=1, bus model returns addr[3:0] -> bus cycles at 1..5 on 0x00100..0x00104; rsp_valid at cycle 7; rsp_rdata=0x0000000000043210; rsp_error=0.
- DP_READ addr=0xFFFFE len=3 -> bus_address sequence FFFFE, FFFFF, 00000, 00001; rdata nibbles match model.
- DP_WRITE addr=0x00120 len=1 wdata=0xA5 -> cycle 1 {0x00120, DP_WRITE, 5}, cycle 2 {0x00121, DP_WRITE, A}; rsp_valid at cycle 3; rsp_error=0.
- DP_READ len=15 with bus_error high during the 3rd bus cycle -> next cycle NOP, no further addresses; rsp_error=1; nibbles 0..1 valid, rest 0.
- Reset asserted mid-ISSUE -> outputs reach reset values without a clock edge; no rsp_valid. A following PC_READ completes normally.
- req_op=11 accepted at cycle 0 -> rsp_valid and rsp_error at cycle 1, no bus command. req_valid held high during a burst is not accepted until IDLE.

Source files
------------

// File: rtl/hp48_bus_master_pkg.sv
// Shared definitions for the HP48 nibble-bus initiator.
// - BUSCMD_* bus command codes driven on bus_command
// - req_op encodings accepted on the request interface
// - initiator FSM state encoding
package hp48_bus_master_pkg;

    localparam logic [3:0] BUSCMD_NOP      = 4'h0;
    localparam logic [3:0] BUSCMD_PC_READ  = 4'h1;
    localparam logic [3:0] BUSCMD_DP_READ  = 4'h2;
    localparam logic [3:0] BUSCMD_DP_WRITE = 4'h3;

    typedef enum logic [1:0] {
        OpPcRead   = 2'b00,
        OpDpRead   = 2'b01,
        OpDpWrite  = 2'b10,
        OpReserved = 2'b11
    } req_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StDone
    } state_e;

    function automatic logic [3:0] op_to_buscmd(req_op_e op);
        logic [3:0] cmd;
        unique case (op)
            OpPcRead:  cmd = BUSCMD_PC_READ;
            OpDpRead:  cmd = BUSCMD_DP_READ;
            OpDpWrite: cmd = BUSCMD_DP_WRITE;
            default:   cmd = BUSCMD_NOP;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/hp48_bus_rd_pipe.sv
// Read-capture delay line for the HP48 bus initiator.
// Carries {valid, nibble index} for each issued read bus cycle so that the
// returning nibble can be written to the right slot LATENCY cycles later.
// Ports:
//   clk, reset   clock / async active-high reset
//   flush        drop every in-flight entry (bus error)
//   in_valid     a read bus cycle is being issued this cycle
//   in_idx       nibble index of that bus cycle
//   cap_valid    bus_nibble_in this cycle belongs to an issued read
//   cap_idx      nibble index to write it to
module hp48_bus_rd_pipe #(
    parameter int unsigned LATENCY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       in_valid,
    input  logic [3:0] in_idx,
    output logic       cap_valid,
    output logic [3:0] cap_idx
);

    if (LATENCY == 0) begin : g_comb
        // Data returns in the same cycle as the bus cycle: capture directly.
        assign cap_valid = in_valid;
        assign cap_idx   = in_idx;
    end else begin : g_pipe
        logic [LATENCY-1:0]      vld_q;
        logic [LATENCY-1:0][3:0] idx_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                vld_q <= '0;
                idx_q <= '0;
            end else if (flush) begin
                vld_q <= '0;
            end else begin
                vld_q[0] <= in_valid;
                idx_q[0] <= in_idx;
                for (int s = 1; s < int'(LATENCY); s++) begin
                    vld_q[s] <= vld_q[s-1];
                    idx_q[s] <= idx_q[s-1];
                end
            end
        end

        assign cap_valid = vld_q[LATENCY-1];
        assign cap_idx   = idx_q[LATENCY-1];
    end

endmodule

// File: rtl/hp48_bus_master.sv
// CPU-side initiator for the HP48 nibble bus.
// Accepts one burst request (PC read, DP read, DP write; 1..16 nibbles) and
// issues it as one nibble bus cycle per clock, gathering read nibbles into a
// 64-bit buffer. A bus_error aborts the burst and reports rsp_error.
// Ports:
//   clk, reset                       clock / async active-high reset
//   req_valid/req_ready              request handshake (ready only when idle)
//   req_op, req_addr, req_len        operation, start address, count-1
//   req_wdata                        write nibbles, nibble i at [4i+3:4i]
//   rsp_valid                        one-cycle completion pulse
//   rsp_rdata, rsp_error             result, held until the next accept
//   bus_address, bus_command         bus cycle address / BUSCMD_* code
//   bus_nibble_out, bus_nibble_in    write nibble out / read nibble in
//   bus_error                        error from the bus manager
module hp48_bus_master
    import hp48_bus_master_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [19:0] req_addr,
    input  logic [3:0]  req_len,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    output logic [63:0] rsp_rdata,
    output logic        rsp_error,
    output logic [19:0] bus_address,
    output logic [3:0]  bus_command,
    output logic [3:0]  bus_nibble_out,
    input  logic [3:0]  bus_nibble_in,
    input  logic        bus_error
);

    localparam logic [1:0] DrainInit = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;

    state_e      state_q, state_d;
    req_op_e     op_q, op_d;
    logic [19:0] addr_q, addr_d;
    logic [3:0]  len_q, len_d;
    logic [63:0] wdata_q, wdata_d;
    logic [3:0]  idx_q, idx_d;
    logic [1:0]  drain_q, drain_d;
    logic [63:0] rdata_q, rdata_d;
    logic        error_q, error_d;

    logic        issue_rd;
    logic        flush;
    logic        cap_valid;
    logic [3:0]  cap_idx;

    hp48_bus_rd_pipe #(
        .LATENCY (READ_LATENCY)
    ) u_rd_pipe (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (issue_rd),
        .in_idx    (idx_q),
        .cap_valid (cap_valid),
        .cap_idx   (cap_idx)
    );

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        addr_d         = addr_q;
        len_d          = len_q;
        wdata_d        = wdata_q;
        idx_d          = idx_q;
        drain_d        = drain_q;
        rdata_d        = rdata_q;
        error_d        = error_q;
        req_ready      = 1'b0;
        rsp_valid      = 1'b0;
        bus_address    = '0;
        bus_command    = BUSCMD_NOP;
        bus_nibble_out = '0;
        issue_rd       = 1'b0;
        flush          = 1'b0;

        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    op_d    = req_op_e'(req_op);
                    addr_d  = req_addr;
                    len_d   = req_len;
                    wdata_d = req_wdata;
                    idx_d   = '0;
                    rdata_d = '0;
                    error_d = 1'b0;
                    if (req_op_e'(req_op) == OpReserved) begin
                        error_d = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end

            StIssue: begin
                bus_address = addr_q + {16'd0, idx_q};
                bus_command = op_to_buscmd(op_q);
                if (op_q == OpDpWrite) begin
                    bus_nibble_out = wdata_q[{idx_q, 2'b00} +: 4];
                end else begin
                    issue_rd = 1'b1;
                end
                // Error takes priority over the last issue.
                if (bus_error) begin
                    flush   = 1'b1;
                    error_d = 1'b1;
                    state_d = StDone;
                end else if (idx_q == len_q) begin
                    if (issue_rd && (READ_LATENCY > 0)) begin
                        drain_d = DrainInit;
                        state_d = StDrain;
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end

            StDrain: begin
                if (bus_error) begin
                    flush   = 1'b1;
                    error_d = 1'b1;
                    state_d = StDone;
                end else if (drain_q == 2'd0) begin
                    state_d = StDone;
                end else begin
                    drain_d = drain_q - 2'd1;
                end
            end

            StDone: begin
                rsp_valid = 1'b1;
                state_d   = StIdle;
            end

            default: state_d = StIdle;
        endcase

        // The nibble returning this cycle is kept even if an error aborts now.
        if (cap_valid) begin
            rdata_d[{cap_idx, 2'b00} +: 4] = bus_nibble_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            op_q    <= OpPcRead;
            addr_q  <= '0;
            len_q   <= '0;
            wdata_q <= '0;
            idx_q   <= '0;
            drain_q <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            wdata_q <= wdata_d;
            idx_q   <= idx_d;
            drain_q <= drain_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

    assign rsp_rdata = rdata_q;
    assign rsp_error = error_q;

endmodule

// File: tb/tb_hp48_bus_master.sv
// Scoreboard bench for hp48_bus_master: requests push expected bus cycles and
// responses into queues; monitors on the falling edge pop and compare.
module tb_hp48_bus_master;
    import hp48_bus_master_pkg::*;

    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = '0;
    logic [19:0] req_addr = '0;
    logic [3:0]  req_len = '0;
    logic [63:0] req_wdata = '0;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_error;
    logic [19:0] bus_address;
    logic [3:0]  bus_command;
    logic [3:0]  bus_nibble_out;
    logic [3:0]  bus_nibble_in;
    logic        bus_error = 1'b0;

    hp48_bus_master #(
        .READ_LATENCY (LAT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_addr       (req_addr),
        .req_len        (req_len),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_error      (rsp_error),
        .bus_address    (bus_address),
        .bus_command    (bus_command),
        .bus_nibble_out (bus_nibble_out),
        .bus_nibble_in  (bus_nibble_in),
        .bus_error      (bus_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          cyc;
        logic [19:0] addr;
        logic [3:0]  cmd;
        logic [3:0]  nib;
    } bus_exp_t;

    typedef struct {
        int          cyc;
        logic [63:0] rdata;
        logic        err;
    } rsp_exp_t;

    bus_exp_t bus_q[$];
    rsp_exp_t rsp_q[$];
    int       err_cycle = -1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    // Bus memory: the nibble stored at an address.
    function automatic logic [3:0] mem_nib(input logic [19:0] a);
        return a[3:0] ^ a[19:16];
    endfunction

    function automatic logic [3:0] exp_cmd(input logic [1:0] op);
        case (op)
            2'b00:   return BUSCMD_PC_READ;
            2'b01:   return BUSCMD_DP_READ;
            2'b10:   return BUSCMD_DP_WRITE;
            default: return BUSCMD_NOP;
        endcase
    endfunction

    // Bus manager model: returns the nibble of the read issued LAT (=1) cycle earlier.
    logic        cur_rd, hist_rd;
    logic [19:0] cur_addr, hist_addr;
    initial begin
        cur_rd = 1'b0; hist_rd = 1'b0; cur_addr = '0; hist_addr = '0;
    end
    always @(negedge clk) begin
        cur_rd   = (bus_command == BUSCMD_PC_READ) || (bus_command == BUSCMD_DP_READ);
        cur_addr = bus_address;
    end
    always @(posedge clk) begin
        hist_rd   <= cur_rd;
        hist_addr <= cur_addr;
    end
    assign bus_nibble_in = hist_rd ? mem_nib(hist_addr) : 4'h0;

    // Error injector: bus_error high for the whole of cycle err_cycle.
    always @(posedge clk) begin
        #1;
        bus_error = (cyc == err_cycle);
    end

    // Bus monitor.
    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            if (bus_command != BUSCMD_NOP) begin
                if (bus_q.size() == 0) begin
                    fail_now("bus_unexpected_cycle");
                end else begin
                    bus_exp_t b;
                    b = bus_q.pop_front();
                    chk("bus_cycle_time", 64'(cyc), 64'(b.cyc));
                    chk("bus_address", 64'(bus_address), 64'(b.addr));
                    chk("bus_command", 64'(bus_command), 64'(b.cmd));
                    chk("bus_nibble_out", 64'(bus_nibble_out), 64'(b.nib));
                end
            end else begin
                chk("bus_idle_nibble", 64'(bus_nibble_out), 64'h0);
            end
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (rsp_q.size() == 0) begin
                fail_now("rsp_unexpected");
            end else begin
                rsp_exp_t r;
                r = rsp_q.pop_front();
                chk("rsp_time", 64'(cyc), 64'(r.cyc));
                chk("rsp_rdata", rsp_rdata, r.rdata);
                chk("rsp_error", 64'(rsp_error), 64'(r.err));
            end
        end
    end

    // Issue one request, push expectations, and return #1 after the edge
    // following its response so another request can go back to back.
    task automatic issue(input logic [1:0] op, input logic [19:0] addr, input logic [3:0] len,
                         input logic [63:0] wdata, input int err_at, input bit hold);
        int       acc, rsp_cyc, nbus, last_cap, tries, n;
        bit       rd, ok;
        rsp_exp_t r;
        bus_exp_t b;
        req_op    = op;
        req_addr  = addr;
        req_len   = len;
        req_wdata = wdata;
        req_valid = 1'b1;
        ok        = 1'b0;
        tries     = 0;
        while (!ok && tries < 50) begin
            @(negedge clk);
            if (req_ready) ok = 1'b1;
            else begin
                tries++;
                @(posedge clk);
                #1;
            end
        end
        if (!ok) begin
            fail_now("accept_timeout");
            req_valid = 1'b0;
            return;
        end
        acc     = cyc;
        n       = int'(len);
        rd      = (op == 2'b00) || (op == 2'b01);
        r.rdata = '0;
        r.err   = 1'b0;
        if (op == 2'b11) begin
            r.err    = 1'b1;
            rsp_cyc  = acc + 1;
            nbus     = 0;
            last_cap = -1;
        end else if (err_at >= 0) begin
            r.err     = 1'b1;
            rsp_cyc   = acc + err_at + 2;
            nbus      = (err_at < n) ? err_at + 1 : n + 1;
            last_cap  = rd ? ((err_at - LAT < n) ? err_at - LAT : n) : -1;
            err_cycle = acc + 1 + err_at;
        end else begin
            rsp_cyc  = acc + n + 2 + (rd ? LAT : 0);
            nbus     = n + 1;
            last_cap = rd ? n : -1;
        end
        for (int k = 0; k < nbus; k++) begin
            b.cyc  = acc + 1 + k;
            b.addr = addr + 20'(k);
            b.cmd  = exp_cmd(op);
            b.nib  = (op == 2'b10) ? wdata[4*k +: 4] : 4'h0;
            bus_q.push_back(b);
        end
        for (int k = 0; k <= last_cap; k++) r.rdata[4*k +: 4] = mem_nib(addr + 20'(k));
        r.cyc = rsp_cyc;
        rsp_q.push_back(r);

        @(posedge clk);
        #1;
        if (hold) begin
            // Keep a garbage request pending; it must be ignored while busy.
            req_op   = 2'($urandom);
            req_addr = 20'($urandom);
        end else begin
            req_valid = 1'b0;
        end
        while (cyc <= rsp_cyc) begin
            @(negedge clk);
            if (hold) chk("busy_not_ready", 64'(req_ready), 64'h0);
            @(posedge clk);
            #1;
        end
        err_cycle = -1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'h1);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'h0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 64'h0);
        chk({tag, "_rsp_error"}, 64'(rsp_error), 64'h0);
        chk({tag, "_bus_address"}, 64'(bus_address), 64'h0);
        chk({tag, "_bus_command"}, 64'(bus_command), 64'(BUSCMD_NOP));
        chk({tag, "_bus_nibble_out"}, 64'(bus_nibble_out), 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  op;
        logic [3:0]  len;
        logic [19:0] addr;
        int          err_at;
        reset = 1'b1;
        #1;
        check_reset_values("por");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Directed cases.
        issue(2'b00, 20'h00100, 4'd4, 64'h0, -1, 1'b0);
        issue(2'b01, 20'hFFFFE, 4'd3, 64'h0, -1, 1'b0);
        issue(2'b10, 20'h00120, 4'd1, 64'hA5, -1, 1'b0);
        issue(2'b01, 20'h00400, 4'd15, 64'h0, 2, 1'b0);
        issue(2'b01, 20'h00500, 4'd5, 64'h0, 5, 1'b0);
        issue(2'b11, 20'h12345, 4'd7, 64'h0, -1, 1'b1);
        issue(2'b10, 20'h00200, 4'd3, 64'hFEDC_BA98_7654_3210, -1, 1'b1);
        req_valid = 1'b0;

        // Reset in the middle of a burst: two bus cycles, then no response.
        @(posedge clk);
        #1;
        req_op = 2'b00; req_addr = 20'h03000; req_len = 4'd10; req_valid = 1'b1;
        @(negedge clk);
        chk("pre_reset_ready", 64'(req_ready), 64'h1);
        for (int k = 0; k < 2; k++) begin
            bus_exp_t b;
            b.cyc = cyc + 1 + k; b.addr = 20'h03000 + 20'(k);
            b.cmd = BUSCMD_PC_READ; b.nib = 4'h0;
            bus_q.push_back(b);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_reset_values("mid_reset");
        @(negedge clk);
        #2;
        reset = 1'b0;
        bus_q.delete();
        rsp_q.delete();
        @(posedge clk);
        #1;
        issue(2'b00, 20'h00100, 4'd4, 64'h0, -1, 1'b0);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            op   = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            len  = 4'($urandom);
            addr = ($urandom_range(0, 3) == 0) ? 20'hFFFF0 + 20'($urandom_range(0, 15))
                                               : 20'($urandom);
            err_at = -1;
            if ($urandom_range(0, 3) == 0) begin
                err_at = (op == 2'b10) ? $urandom_range(0, int'(len))
                                       : $urandom_range(0, int'(len) + LAT);
            end
            issue(op, addr, len, {$urandom, $urandom}, err_at, 1'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                req_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        req_valid = 1'b0;

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("bus_queue_drained", 64'(bus_q.size()), 64'h0);
        chk("rsp_queue_drained", 64'(rsp_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
